// File: rtl/mipi_dphy_lane_ctrl_if.sv
// ---------------------------------------------------------------------------
// mipi_dphy_lane_ctrl_if
//
// Purpose:
//   Byte-stream handshake between the DSI packet builder (master) and the
//   D-PHY lane sequencer (slave).
//
// Signals:
//   tx_req    master->slave  request an HS burst
//   tx_data   master->slave  payload byte, bit0 transmitted first
//   tx_valid  master->slave  tx_data is valid
//   tx_last   master->slave  marks the final payload byte
//   tx_ready  slave->master  byte accepted when tx_valid & tx_ready
// ---------------------------------------------------------------------------
interface mipi_dphy_lane_ctrl_if;

   logic       tx_req;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   // The packet builder drives the request and the byte stream.
   modport master (
      output tx_req,
      output tx_data,
      output tx_valid,
      output tx_last,
      input  tx_ready
   );

   // The lane sequencer consumes the stream and paces it with tx_ready.
   modport slave (
      input  tx_req,
      input  tx_data,
      input  tx_valid,
      input  tx_last,
      output tx_ready
   );

endinterface

// File: rtl/mipi_dphy_lane_ctrl.sv
// ---------------------------------------------------------------------------
// mipi_dphy_lane_ctrl
//
// Purpose:
//   Sequencer for a single-data-lane MIPI D-PHY transmitter. Walks the clock
//   lane and data lane 0 through LP-to-HS entry, SoT, payload, trail and
//   HS-to-LP exit, feeding the PHY wrapper from a byte-stream handshake.
//
// Ports:
//   byte_clk     in   byte clock, all state changes on its rising edge
//   reset_n      in   asynchronous, active-low reset
//   tx           slave modport of mipi_dphy_lane_ctrl_if
//                (tx_req, tx_data, tx_valid, tx_last in; tx_ready out)
//   busy         out  high in every state except IDLE
//   underrun_err out  one-cycle pulse when the payload runs dry
//   hs_clk_en    out  clock lane in HS
//   hsxx_clk_en  out  clock lane toggling
//   hs_data_en   out  data lane 0 in HS
//   lpclk_out    out  clock-lane LP levels {P,N}
//   lp0_out      out  data-lane LP levels {P,N}
//   byte_D0      out  HS byte to the serializer
// ---------------------------------------------------------------------------
module mipi_dphy_lane_ctrl #(
   parameter int T_LPX       = 2,
   parameter int T_CLK_PREP  = 1,
   parameter int T_CLK_ZERO  = 8,
   parameter int T_CLK_PRE   = 2,
   parameter int T_HS_PREP   = 2,
   parameter int T_HS_ZERO   = 4,
   parameter int T_HS_TRAIL  = 3,
   parameter int T_CLK_POST  = 4,
   parameter int T_CLK_TRAIL = 2,
   parameter int T_HS_EXIT   = 3,
   parameter int CNT_W       = 8
) (
   input  logic                        byte_clk,
   input  logic                        reset_n,
   mipi_dphy_lane_ctrl_if.slave        tx,
   output logic                        busy,
   output logic                        underrun_err,
   output logic                        hs_clk_en,
   output logic                        hsxx_clk_en,
   output logic                        hs_data_en,
   output logic [1:0]                  lpclk_out,
   output logic [1:0]                  lp0_out,
   output logic [7:0]                  byte_D0
);

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   typedef enum logic [3:0] {
      IDLE,
      CLK_LPX,
      CLK_PREP,
      CLK_ZERO,
      CLK_PRE,
      D_LPX,
      D_PREP,
      D_ZERO,
      D_SYNC,
      D_PAYLOAD,
      D_TRAIL,
      CLK_POST,
      CLK_TRAIL,
      HS_EXIT
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   timer;
   logic [CNT_W-1:0]   timer_nxt;
   logic               last_flag;
   logic               last_nxt;
   logic [7:0]         byte_nxt;
   logic               underrun_nxt;
   logic               timer_done;
   logic               accept;
   logic [7:0]         trail_byte;

   logic [1:0]         lpclk_nxt;
   logic [1:0]         lp0_nxt;
   logic               hs_clk_nxt;
   logic               hsxx_clk_nxt;
   logic               hs_data_nxt;

   // Each timed state counts down from T-1 to 0, so it lasts exactly T cycles.
   function automatic logic [CNT_W-1:0] timer_load(input state_t s);
      case (s)
         CLK_LPX, D_LPX: timer_load = CNT_W'(T_LPX - 1);
         CLK_PREP:       timer_load = CNT_W'(T_CLK_PREP - 1);
         CLK_ZERO:       timer_load = CNT_W'(T_CLK_ZERO - 1);
         CLK_PRE:        timer_load = CNT_W'(T_CLK_PRE - 1);
         D_PREP:         timer_load = CNT_W'(T_HS_PREP - 1);
         D_ZERO:         timer_load = CNT_W'(T_HS_ZERO - 1);
         D_TRAIL:        timer_load = CNT_W'(T_HS_TRAIL - 1);
         CLK_POST:       timer_load = CNT_W'(T_CLK_POST - 1);
         CLK_TRAIL:      timer_load = CNT_W'(T_CLK_TRAIL - 1);
         HS_EXIT:        timer_load = CNT_W'(T_HS_EXIT - 1);
         default:        timer_load = '0;
      endcase
   endfunction

   // tx_ready is the one unregistered output: the sequencer takes a byte in
   // the sync cycle and in every payload cycle until the last byte is held.
   assign tx.tx_ready = (state == D_SYNC) || ((state == D_PAYLOAD) && !last_flag);
   assign accept      = tx.tx_ready & tx.tx_valid;
   assign timer_done  = (timer == '0);
   // The trail drives the inverse of the final transmitted bit so the lane
   // sees a transition into the trail level.
   assign trail_byte  = {8{~byte_D0[7]}};

   // Next-state, timer and data-path decisions. The payload path covers three
   // exits from the streaming states: a normal accept, an underrun (ready but
   // nothing valid), or the held last byte moving on into the trail.
   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer_done ? timer : timer - 1'b1;
      byte_nxt     = 8'h00;
      last_nxt     = last_flag;
      underrun_nxt = 1'b0;
      case (state)
         IDLE:      if (tx.tx_req)  state_nxt = CLK_LPX;
         CLK_LPX:   if (timer_done) state_nxt = CLK_PREP;
         CLK_PREP:  if (timer_done) state_nxt = CLK_ZERO;
         CLK_ZERO:  if (timer_done) state_nxt = CLK_PRE;
         CLK_PRE:   if (timer_done) state_nxt = D_LPX;
         D_LPX:     if (timer_done) state_nxt = D_PREP;
         D_PREP:    if (timer_done) state_nxt = D_ZERO;
         D_ZERO: begin
            if (timer_done) begin
               state_nxt = D_SYNC;
               byte_nxt  = SYNC_BYTE;
            end
         end
         D_SYNC, D_PAYLOAD: begin
            if (accept) begin
               state_nxt = D_PAYLOAD;
               byte_nxt  = tx.tx_data;
               last_nxt  = tx.tx_last;
            end else begin
               state_nxt    = D_TRAIL;
               byte_nxt     = trail_byte;
               last_nxt     = 1'b0;
               underrun_nxt = tx.tx_ready;
            end
         end
         D_TRAIL: begin
            if (timer_done) state_nxt = CLK_POST;
            else            byte_nxt  = byte_D0;
         end
         CLK_POST:  if (timer_done) state_nxt = CLK_TRAIL;
         CLK_TRAIL: if (timer_done) state_nxt = HS_EXIT;
         HS_EXIT:   if (timer_done) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (state_nxt != state) begin
         timer_nxt = timer_load(state_nxt);
      end
   end

   // Lane levels are decoded from the upcoming state so the registered
   // outputs line up with the state they belong to.
   always_comb begin
      lpclk_nxt    = 2'b00;
      lp0_nxt      = 2'b11;
      hs_clk_nxt   = 1'b0;
      hsxx_clk_nxt = 1'b0;
      hs_data_nxt  = 1'b0;
      case (state_nxt)
         IDLE, HS_EXIT: lpclk_nxt = 2'b11;
         CLK_LPX:       lpclk_nxt = 2'b01;
         CLK_PREP:      lpclk_nxt = 2'b00;
         CLK_ZERO, CLK_TRAIL: hs_clk_nxt = 1'b1;
         CLK_PRE, CLK_POST: begin
            hs_clk_nxt   = 1'b1;
            hsxx_clk_nxt = 1'b1;
         end
         D_LPX: begin
            hs_clk_nxt   = 1'b1;
            hsxx_clk_nxt = 1'b1;
            lp0_nxt      = 2'b01;
         end
         D_PREP: begin
            hs_clk_nxt   = 1'b1;
            hsxx_clk_nxt = 1'b1;
            lp0_nxt      = 2'b00;
         end
         D_ZERO, D_SYNC, D_PAYLOAD, D_TRAIL: begin
            hs_clk_nxt   = 1'b1;
            hsxx_clk_nxt = 1'b1;
            lp0_nxt      = 2'b00;
            hs_data_nxt  = 1'b1;
         end
         default: lpclk_nxt = 2'b11;
      endcase
   end

   // Single register bank for the sequencer: state, timer, data path and all
   // PHY-facing outputs. Reset parks both lanes in LP-11 with HS disabled.
   always_ff @(posedge byte_clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         timer        <= '0;
         last_flag    <= 1'b0;
         byte_D0      <= 8'h00;
         underrun_err <= 1'b0;
         busy         <= 1'b0;
         lpclk_out    <= 2'b11;
         lp0_out      <= 2'b11;
         hs_clk_en    <= 1'b0;
         hsxx_clk_en  <= 1'b0;
         hs_data_en   <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         last_flag    <= last_nxt;
         byte_D0      <= byte_nxt;
         underrun_err <= underrun_nxt;
         busy         <= (state_nxt != IDLE);
         lpclk_out    <= lpclk_nxt;
         lp0_out      <= lp0_nxt;
         hs_clk_en    <= hs_clk_nxt;
         hsxx_clk_en  <= hsxx_clk_nxt;
         hs_data_en   <= hs_data_nxt;
      end
   end

endmodule
